// File: rtl/vecmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vecmac_pkg
//  Description : Shared definitions for the int8_vecmac multiplier path:
//                requester FSM state encoding, operand/product widths and a
//                constant-evaluable ceil(log2) helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vecmac_pkg;

  localparam int OPW   = 4;  // multiplier operand width
  localparam int PRODW = 8;  // multiplier product width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_REQ   = 3'd2,
    ST_CAPT  = 3'd3,
    ST_REL   = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : Multi-flop synchronizer for a single asynchronous level.
//                Asynchronous active-high reset clears every stage to 0.
//  Ports       : clk   - destination clock
//                reset - asynchronous, active-high
//                d     - asynchronous input level
//                q     - synchronized level (STAGES clk of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mul_vec_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : mul_vec_initiator
//  Description : Requester side of the 4x4 self-timed multiplier start/Finish
//                handshake. Accepts a vector of N_ELEM operand pairs, issues
//                one multiply per pair and returns the dot product.
//  Ports       : clk, reset          - clock, async active-high reset
//                cmd_valid/cmd_ready - host command handshake
//                a_vec, b_vec        - packed operands, element i at [4i+3:4i]
//                res_valid           - 1-cycle result strobe
//                res_data, res_err   - sum of products / timeout abort flag
//                mul_start, mul_a/b  - request to the multiplier
//                mul_o, mul_finish   - multiplier product / async Finish
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_vec_initiator
  import vecmac_pkg::*;
#(
  parameter int N_ELEM      = 4,
  parameter int ACC_W       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OPW*N_ELEM-1:0] a_vec,
  input  logic [OPW*N_ELEM-1:0] b_vec,
  output logic                  res_valid,
  output logic [ACC_W-1:0]      res_data,
  output logic                  res_err,
  output logic                  mul_start,
  output logic [OPW-1:0]        mul_a,
  output logic [OPW-1:0]        mul_b,
  input  logic [PRODW-1:0]      mul_o,
  input  logic                  mul_finish
);

  localparam int VEC_W = OPW * N_ELEM;
  localparam int IDX_W = (N_ELEM > 1) ? clog2(N_ELEM) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ELEM - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  state_e             state_q,     state_d;
  logic [VEC_W-1:0]   a_q,         a_d;
  logic [VEC_W-1:0]   b_q,         b_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [TMR_W-1:0]   timer_q,     timer_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [PRODW-1:0]   prod_q,      prod_d;
  logic               mul_start_q, mul_start_d;
  logic               res_valid_q, res_valid_d;
  logic [ACC_W-1:0]   res_data_q,  res_data_d;
  logic               res_err_q,   res_err_d;

  logic fin_s;
  logic timed_out;

  // Finish comes from a self-timed block; only its synchronized copy is used.
  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_fin_sync (
    .clk   (clk),
    .reset (reset),
    .d     (mul_finish),
    .q     (fin_s)
  );

  assign timed_out = (timer_q >= TMR_LIMIT);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    timer_d     = '0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          a_d     = a_vec;
          b_d     = b_vec;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_SETUP;
        end
      end
      // A Finish still high here (stale from an aborted request) must clear
      // before a new start may rise; it is timed like the other wait phases.
      ST_SETUP: begin
        if (!fin_s)         state_d = ST_REQ;
        else if (timed_out) state_d = ST_ERR;
      end
      ST_REQ: begin
        if (fin_s) begin
          prod_d  = mul_o;
          state_d = ST_CAPT;
        end else if (timed_out) begin
          state_d = ST_ERR;
        end
      end
      ST_CAPT: begin
        acc_d   = acc_q + ACC_W'(prod_q);
        state_d = ST_REL;
      end
      ST_REL: begin
        if (!fin_s)         state_d = ST_NEXT;
        else if (timed_out) state_d = ST_ERR;
      end
      ST_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SETUP;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Timer restarts on every state change and only runs in wait phases.
    if ((state_d == state_q) &&
        ((state_q == ST_SETUP) || (state_q == ST_REQ) || (state_q == ST_REL))) begin
      timer_d = timer_q + TMR_W'(1);
    end

    // Registered outputs are loaded on entry so they are live in the state.
    mul_start_d = (state_d == ST_REQ);
    if (state_d == ST_DONE) begin
      res_valid_d = 1'b1;
      res_data_d  = acc_q;
      res_err_d   = 1'b0;
    end else if (state_d == ST_ERR) begin
      res_valid_d = 1'b1;
      res_data_d  = '0;
      res_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      mul_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      mul_start_q <= mul_start_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  // Operand select from the latched vectors; idx only moves while start is low.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        mul_a = a_q[i*OPW +: OPW];
        mul_b = b_q[i*OPW +: OPW];
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign mul_start = mul_start_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_vec_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_vec_initiator
//  Description : Scoreboard bench for mul_vec_initiator with a self-timed
//                multiplier model, random operand vectors, stuck-multiplier
//                timeout, mid-request reset and back-to-back commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_vec_initiator;

  localparam int N_ELEM      = 4;
  localparam int ACC_W       = 12;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;
  localparam int VEC_W       = 4 * N_ELEM;

  logic              clk        = 1'b0;
  logic              reset      = 1'b1;
  logic              cmd_valid  = 1'b0;
  logic              cmd_ready;
  logic [VEC_W-1:0]  a_vec      = '0;
  logic [VEC_W-1:0]  b_vec      = '0;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_err;
  logic              mul_start;
  logic [3:0]        mul_a;
  logic [3:0]        mul_b;
  logic [7:0]        mul_o      = '0;
  logic              mul_finish = 1'b0;

  mul_vec_initiator #(
    .N_ELEM      (N_ELEM),
    .ACC_W       (ACC_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .a_vec      (a_vec),
    .b_vec      (b_vec),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_err    (res_err),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_o      (mul_o),
    .mul_finish (mul_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [ACC_W-1:0] data;
    logic             err;
    int               pulses;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   stuck      = 1'b0;
  int   pulse_cnt  = 0;

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: dot product of the unpacked nibble vectors; a stuck multiplier
  // aborts on the first request with a zero result.
  function automatic exp_t model(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                                 input bit stk);
    exp_t e;
    int   sum;
    sum = 0;
    for (int i = 0; i < N_ELEM; i++) begin
      sum += int'(a[i*4 +: 4]) * int'(b[i*4 +: 4]);
    end
    e.a      = a;
    e.b      = b;
    e.err    = stk;
    e.data   = stk ? '0 : ACC_W'(sum);
    e.pulses = stk ? 1 : N_ELEM;
    return e;
  endfunction

  // Self-timed multiplier: Finish rises and falls at random times unrelated to clk.
  initial begin
    forever begin
      @(posedge mul_start);
      if (!stuck) begin
        #($urandom_range(3, 25));
        if (mul_start) begin
          mul_o      = {4'b0, mul_a} * {4'b0, mul_b};
          mul_finish = 1'b1;
        end
        wait (!mul_start);
        #($urandom_range(3, 25));
        mul_finish = 1'b0;
      end
    end
  end

  // Monitor: protocol checks and scoreboard pops, sampled 1 time unit after clk rise.
  initial begin
    bit               prev_start;
    bit               have_fall;
    int               cyc;
    int               fall_cyc;
    logic [3:0]       held_a;
    logic [3:0]       held_b;
    logic [VEC_W-1:0] va;
    logic [VEC_W-1:0] vb;
    exp_t             e;
    prev_start = 1'b0;
    have_fall  = 1'b0;
    cyc        = 0;
    fall_cyc   = 0;
    held_a     = '0;
    held_b     = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        prev_start = 1'b0;
        have_fall  = 1'b0;
      end else begin
        if (mul_start && !prev_start) begin
          check("start_rise_finish_low", longint'(mul_finish), 0);
          if (have_fall) check("start_low_gap_ge2", longint'((cyc - fall_cyc) >= 2), 1);
          if (sb_q.size() > 0 && pulse_cnt < N_ELEM) begin
            va = sb_q[0].a;
            vb = sb_q[0].b;
            check("mul_a_element", longint'(mul_a), longint'(va[pulse_cnt*4 +: 4]));
            check("mul_b_element", longint'(mul_b), longint'(vb[pulse_cnt*4 +: 4]));
          end
          held_a = mul_a;
          held_b = mul_b;
          pulse_cnt++;
        end else if (mul_start && prev_start) begin
          check("operands_stable", longint'({mul_a, mul_b}), longint'({held_a, held_b}));
        end else if (!mul_start && prev_start) begin
          fall_cyc  = cyc;
          have_fall = 1'b1;
        end
        prev_start = mul_start;

        if (res_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_res_valid", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("res_data", longint'(res_data), longint'(e.data));
            check("res_err", longint'(res_err), longint'(e.err));
            check("start_pulses", longint'(pulse_cnt), longint'(e.pulses));
            if (e.err) check("start_low_on_err", longint'(mul_start), 0);
          end
          pulse_cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b, input bit hold);
    int budget;
    cmd_valid = 1'b1;
    a_vec     = a;
    b_vec     = b;
    budget    = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      sb_q.push_back(model(a, b, stuck));
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      check("result_timeout", longint'(sb_q.size()), 0);
      sb_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int budget;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", longint'(cmd_ready), 0);
    check("reset_mul_start", longint'(mul_start), 0);
    check("reset_res_valid", longint'(res_valid), 0);
    check("reset_res_data", longint'(res_data), 0);
    check("reset_res_err", longint'(res_err), 0);
    check("reset_mul_ab", longint'({mul_a, mul_b}), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("cmd_ready_after_reset", longint'(cmd_ready), 1);

    // directed sum (20) and all-max operands (900)
    send(16'h3210, 16'h4321, 1'b0);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b0);
    drain();

    // random vectors
    repeat (12) begin
      send(VEC_W'($urandom), VEC_W'($urandom), 1'b0);
      drain();
    end

    // multiplier never answers: timeout abort
    stuck = 1'b1;
    send(VEC_W'($urandom), VEC_W'($urandom), 1'b0);
    drain();
    stuck = 1'b0;
    send(VEC_W'($urandom), VEC_W'($urandom), 1'b0);
    drain();

    // reset while requesting element 2
    send(VEC_W'($urandom), VEC_W'($urandom), 1'b0);
    budget = 0;
    while (pulse_cnt < 3 && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    check("reached_element2", longint'(pulse_cnt), 3);
    #3;
    check("start_high_before_reset", longint'(mul_start), 1);
    reset = 1'b1;
    #1;
    check("start_async_drop", longint'(mul_start), 0);
    sb_q.delete();
    pulse_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    send(16'h3210, 16'h4321, 1'b0);
    drain();

    // back-to-back with cmd_valid held high
    send(VEC_W'($urandom), VEC_W'($urandom), 1'b1);
    send(VEC_W'($urandom), VEC_W'($urandom), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
